fx3_packet_sequencer: RTL

Controller in the fx3_clock domain that sequences packet transfers from the sample FIFO to the FX3 GPIF bus. It watches the FIFO's data-available and buffer-error flags and the FX3 DMA-ready flag, issues exactly one packet of FIFO read requests per transfer, and produces a write strobe aligned to the registered 16-bit output data. It also counts completed packets and latches buffer errors for the host.

---
 rtl/fx3_packet_sequencer_pkg.sv | 18 +
 rtl/fx3_strobe_delay.sv | 32 +++
 rtl/fx3_packet_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fx3_packet_sequencer_pkg.sv
// fx3_packet_sequencer_pkg: shared state encoding and default
// packet/latency/guard constants for the FX3 packet sequencer.
package fx3_packet_sequencer_pkg;

  localparam int unsigned DEF_PACKET_WORDS = 8192;
  localparam int unsigned DEF_READ_LATENCY = 2;
  localparam int unsigned DEF_GUARD_CYCLES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_BURST,
    S_DRAIN,
    S_HOLDOFF,
    S_ERROR
  } seq_state_t;

endpackage

// File: rtl/fx3_strobe_delay.sv
// fx3_strobe_delay: STAGES-deep shift register that re-times the
// FIFO read request into the GPIF write strobe.
module fx3_strobe_delay #(
  parameter int unsigned STAGES = 2
) (
  input  logic fx3_clock,
  input  logic nReset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sr;

  generate
    if (STAGES == 1) begin : g_one
      // single stage: plain register
      always_ff @(posedge fx3_clock or negedge nReset) begin
        if (!nReset) sr <= '0;
        else         sr <= din;
      end
    end else begin : g_many
      // multi stage: shift toward the MSB
      always_ff @(posedge fx3_clock or negedge nReset) begin
        if (!nReset) sr <= '0;
        else         sr <= {sr[STAGES-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[STAGES-1];

endmodule

// File: rtl/fx3_packet_sequencer.sv
// fx3_packet_sequencer: issues one full packet of FIFO reads per
// FX3 transfer, counts packets and latches buffer errors.
module fx3_packet_sequencer
  import fx3_packet_sequencer_pkg::*;
#(
  parameter int unsigned PACKET_WORDS = DEF_PACKET_WORDS,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic        fx3_clock,
  input  logic        nReset,
  input  logic        collectData,
  input  logic        dataAvailable,
  input  logic        bufferError,
  input  logic        fx3Ready,
  output logic        readData,
  output logic        fx3Write,
  output logic [15:0] packetCount,
  output logic        errorLatched,
  output logic        busy
);

  localparam int CW = $clog2(PACKET_WORDS);
  localparam int HW =
    (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [CW-1:0] LAST_WORD =
    CW'(PACKET_WORDS - 1);
  localparam logic [CW-1:0] LAST_DRAIN =
    CW'(READ_LATENCY - 1);
  localparam logic [HW-1:0] LAST_GUARD =
    HW'(GUARD_CYCLES - 1);

  seq_state_t    state;
  logic [CW-1:0] word_cnt;
  logic [HW-1:0] hold_cnt;
  logic          pend;
  logic          read_q;
  logic          busy_q;
  logic          err_q;
  logic [15:0]   pkt_cnt;

  // packet sequencing FSM with registered outputs
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      hold_cnt <= '0;
      pend     <= 1'b0;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (collectData) begin
            pkt_cnt <= '0;
            state   <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (!collectData) begin
            state <= S_IDLE;
          end else if (bufferError) begin
            state <= S_ERROR;
            err_q <= 1'b1;
          end else if (dataAvailable && fx3Ready) begin
            state    <= S_BURST;
            read_q   <= 1'b1;
            busy_q   <= 1'b1;
            pend     <= 1'b0;
            word_cnt <= LAST_WORD;
          end
        end
        S_BURST: begin
          if (bufferError) pend <= 1'b1;
          if (word_cnt == '0) begin
            state    <= S_DRAIN;
            read_q   <= 1'b0;
            word_cnt <= LAST_DRAIN;
          end else begin
            word_cnt <= word_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          if (bufferError) pend <= 1'b1;
          if (word_cnt == '0) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            busy_q  <= 1'b0;
            pend    <= 1'b0;
            if (pend || bufferError) begin
              state <= S_ERROR;
              err_q <= 1'b1;
            end else if (!collectData) begin
              state <= S_IDLE;
            end else begin
              state    <= S_HOLDOFF;
              hold_cnt <= LAST_GUARD;
            end
          end else begin
            word_cnt <= word_cnt - 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (!collectData) begin
            state <= S_IDLE;
          end else if (hold_cnt == '0) begin
            state <= S_WAIT_DATA;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        S_ERROR: begin
          if (!collectData) begin
            state <= S_IDLE;
            err_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fx3_strobe_delay #(
    .STAGES(READ_LATENCY)
  ) u_delay (
    .fx3_clock(fx3_clock),
    .nReset   (nReset),
    .din      (read_q),
    .dout     (fx3Write)
  );

  assign readData     = read_q;
  assign busy         = busy_q;
  assign errorLatched = err_q;
  assign packetCount  = pkt_cnt;

endmodule
